adder_arbiter: RTL and testbench

- Shares one registered 8-bit adder datapath between NUM_REQ requesters.
- The adder takes din_vld/din_a/din_b, returns dout_vld/dout one cycle later and has a 9-bit result.
- Grants requesters round-robin, issues one operation, waits for the result with a timeout, and returns it tagged with the requester ID.
- Sits between the requesting client blocks and the adder instance.

---
 rtl/adder_arb_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/adder_arbiter.sv | 159 +++++++++++++++
 tb/tb_adder_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_arb_pkg.sv
// Shared types, default sizes and helpers for the adder arbiter slice.
package adder_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam int DEF_DW      = 8;
   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_TIMEOUT = 15;
   localparam int MAX_REQ     = 16;

   // Wide enough for the largest supported requester count; callers narrow it.
   function automatic logic [MAX_REQ-1:0] onehot(input logic [3:0] idx);
      logic [MAX_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request above last_grant,
// wrapping around, found by rotating a doubled copy of the request vector.
module rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int IDW     = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDW-1:0]     last_grant,
   output logic [IDW-1:0]     grant,
   output logic               any_req
);

   localparam logic [IDW:0]   START_ONE = (IDW+1)'(1);
   localparam logic [IDW+1:0] NREQ_W    = (IDW+2)'(NUM_REQ);

   logic [2*NUM_REQ-1:0] w_dbl;
   logic [IDW:0]         w_start;
   logic [NUM_REQ-1:0]   w_rot;
   logic [IDW:0]         w_offset;
   logic                 w_found;
   logic [IDW+1:0]       w_raw;

   assign w_dbl   = {req, req};
   assign w_start = {1'b0, last_grant} + START_ONE;
   assign w_rot   = NUM_REQ'(w_dbl >> w_start);
   assign any_req = |req;

   // Bit 0 of the rotated vector is requester last_grant+1.
   always_comb begin
      w_found  = 1'b0;
      w_offset = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!w_found && w_rot[i]) begin
            w_found  = 1'b1;
            w_offset = (IDW+1)'(i);
         end
      end
   end

   assign w_raw = {1'b0, w_start} + {1'b0, w_offset};
   assign grant = IDW'((w_raw >= NREQ_W) ? (w_raw - NREQ_W) : w_raw);

endmodule

// File: rtl/adder_arbiter.sv
// Shares one registered adder between NUM_REQ requesters: round-robin grant,
// single issue, bounded wait for the result, response tagged with requester ID.
module adder_arbiter
   import adder_arb_pkg::*;
#(
   parameter  int NUM_REQ = DEF_NUM_REQ,
   parameter  int DW      = DEF_DW,
   parameter  int TIMEOUT = DEF_TIMEOUT,
   localparam int IDW     = $clog2(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  rst_in,
   input  logic [NUM_REQ-1:0]    req_vld,
   input  logic [NUM_REQ*DW-1:0] req_a,
   input  logic [NUM_REQ*DW-1:0] req_b,
   output logic [NUM_REQ-1:0]    req_rdy,
   output logic                  add_vld,
   output logic [DW-1:0]         add_a,
   output logic [DW-1:0]         add_b,
   input  logic                  add_dout_vld,
   input  logic [DW:0]           add_dout,
   output logic                  rsp_vld,
   output logic [IDW-1:0]        rsp_id,
   output logic [DW:0]           rsp_data,
   output logic                  rsp_err,
   input  logic                  rsp_rdy,
   output logic                  busy
);

   localparam int           CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);

   state_t r_state;
   state_t w_stateNext;

   logic [IDW-1:0]     r_lastGrant;
   logic [IDW-1:0]     r_reqId;
   logic [CW-1:0]      r_waitCnt;
   logic               r_addVld;
   logic [DW-1:0]      r_addA;
   logic [DW-1:0]      r_addB;
   logic               r_rspVld;
   logic [IDW-1:0]     r_rspId;
   logic [DW:0]        r_rspData;
   logic               r_rspErr;
   logic               r_busy;

   logic [IDW-1:0]     w_grant;
   logic               w_anyReq;
   logic [NUM_REQ-1:0] w_grantOh;
   logic [DW-1:0]      w_selA;
   logic [DW-1:0]      w_selB;
   logic               w_accept;
   logic               w_respond;

   rr_arbiter #(
      .NUM_REQ(NUM_REQ)
   ) u_rr (
      .req       (req_vld),
      .last_grant(r_lastGrant),
      .grant     (w_grant),
      .any_req   (w_anyReq)
   );

   assign w_grantOh = NUM_REQ'(onehot(4'(w_grant)));
   assign w_selA    = req_a[w_grant*DW +: DW];
   assign w_selB    = req_b[w_grant*DW +: DW];
   assign req_rdy   = (r_state == IDLE) ? (w_grantOh & req_vld) : '0;

   always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // A result arriving on the last allowed wait cycle beats the timeout.
   always_comb begin
      w_stateNext = r_state;
      w_accept    = 1'b0;
      w_respond   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_anyReq) begin
               w_accept    = 1'b1;
               w_stateNext = ISSUE;
            end
         end
         ISSUE: begin
            w_stateNext = WAIT;
         end
         WAIT: begin
            if (add_dout_vld || (r_waitCnt == LAST_CNT)) begin
               w_respond   = 1'b1;
               w_stateNext = RESP;
            end
         end
         RESP: begin
            if (rsp_rdy) begin
               w_stateNext = IDLE;
            end
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in) begin
         r_lastGrant <= LAST_ID;
         r_reqId     <= '0;
         r_waitCnt   <= '0;
         r_addVld    <= 1'b0;
         r_addA      <= '0;
         r_addB      <= '0;
         r_rspVld    <= 1'b0;
         r_rspId     <= '0;
         r_rspData   <= '0;
         r_rspErr    <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_addVld <= w_accept;
         r_busy   <= (w_stateNext != IDLE);
         if (w_accept) begin
            r_addA      <= w_selA;
            r_addB      <= w_selB;
            r_reqId     <= w_grant;
            r_lastGrant <= w_grant;
         end
         if (r_state == ISSUE) begin
            r_waitCnt <= '0;
         end else if ((r_state == WAIT) && !add_dout_vld) begin
            r_waitCnt <= r_waitCnt + CNT_ONE;
         end
         if (w_respond) begin
            r_rspVld  <= 1'b1;
            r_rspId   <= r_reqId;
            r_rspData <= add_dout_vld ? add_dout : '0;
            r_rspErr  <= !add_dout_vld;
         end else if ((r_state == RESP) && rsp_rdy) begin
            r_rspVld <= 1'b0;
         end
      end
   end

   assign add_vld  = r_addVld;
   assign add_a    = r_addA;
   assign add_b    = r_addB;
   assign rsp_vld  = r_rspVld;
   assign rsp_id   = r_rspId;
   assign rsp_data = r_rspData;
   assign rsp_err  = r_rspErr;
   assign busy     = r_busy;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed vectors, corner sequences
// and randomized traffic scored against a queue-based reference model.
module tb_adder_arbiter;

   logic        clk;
   logic        rst_in;
   logic [3:0]  req_vld;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [3:0]  req_rdy;
   logic        add_vld;
   logic [7:0]  add_a;
   logic [7:0]  add_b;
   logic        add_dout_vld;
   logic [8:0]  add_dout;
   logic        rsp_vld;
   logic [1:0]  rsp_id;
   logic [8:0]  rsp_data;
   logic        rsp_err;
   logic        rsp_rdy;
   logic        busy;

   logic        modelVld;
   logic [8:0]  modelData;
   logic        silent;
   logic        manualVld;
   logic [8:0]  manualData;

   int total;
   int bad;

   typedef struct {
      logic [3:0]  vld;
      logic [31:0] a;
      logic [31:0] b;
      int          expId;
      int          expSum;
   } vec_t;

   typedef struct {
      int id;
      int sum;
   } exp_t;

   vec_t vecs[7];
   exp_t expQ[$];
   int   mLast;
   int   nRspRnd;

   adder_arbiter #(
      .NUM_REQ(4),
      .DW     (8),
      .TIMEOUT(15)
   ) dut (
      .clk         (clk),
      .rst_in      (rst_in),
      .req_vld     (req_vld),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_rdy     (req_rdy),
      .add_vld     (add_vld),
      .add_a       (add_a),
      .add_b       (add_b),
      .add_dout_vld(add_dout_vld),
      .add_dout    (add_dout),
      .rsp_vld     (rsp_vld),
      .rsp_id      (rsp_id),
      .rsp_data    (rsp_data),
      .rsp_err     (rsp_err),
      .rsp_rdy     (rsp_rdy),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One-cycle adder model; 'silent' makes it swallow requests.
   always @(posedge clk) begin
      modelVld  <= add_vld && !silent;
      modelData <= 9'(add_a) + 9'(add_b);
   end

   assign add_dout_vld = modelVld | manualVld;
   assign add_dout     = manualVld ? manualData : modelData;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] vld, input logic [31:0] a, input logic [31:0] b);
      req_vld = vld;
      req_a   = a;
      req_b   = b;
      #1;
   endtask

   task automatic doReset();
      rst_in     = 1'b1;
      req_vld    = '0;
      req_a      = '0;
      req_b      = '0;
      rsp_rdy    = 1'b1;
      silent     = 1'b0;
      manualVld  = 1'b0;
      manualData = '0;
      tick();
      tick();
      rst_in = 1'b0;
      #1;
   endtask

   task automatic waitRsp(input int budget);
      int n;
      n = 0;
      while (!rsp_vld && n < budget) begin
         tick();
         n++;
      end
      checkOutput("response arrives", 32'(rsp_vld), 1);
   endtask

   function automatic int laneSum(input logic [31:0] a, input logic [31:0] b, input int id);
      return int'(a[id*8 +: 8]) + int'(b[id*8 +: 8]);
   endfunction

   function automatic int modelWinner(input int last, input logic [3:0] vld);
      for (int k = 1; k <= 4; k++) begin
         if (vld[(last + k) % 4]) return (last + k) % 4;
      end
      return -1;
   endfunction

   task automatic scoreRsp();
      exp_t e;
      if (rsp_vld && rsp_rdy) begin
         checkOutput("rnd response expected", 32'(expQ.size() != 0), 1);
         if (expQ.size() != 0) begin
            e = expQ.pop_front();
            checkOutput("rnd rsp_id", 32'(rsp_id), 32'(e.id));
            checkOutput("rnd rsp_data", 32'(rsp_data), 32'(e.sum));
            checkOutput("rnd rsp_err", 32'(rsp_err), 0);
            nRspRnd++;
         end
      end
   endtask

   initial begin
      int n;
      int nRsp;
      int w;
      int expIds[6];
      exp_t e;

      total = 0;
      bad   = 0;
      expIds = '{0, 1, 2, 3, 0, 1};

      vecs[0] = '{4'b0001, 32'h000000C8, 32'h00000064, 0, 300};
      vecs[1] = '{4'b1010, 32'hFF001100, 32'hFF000300, 1, 20};
      vecs[2] = '{4'b1010, 32'hFF001100, 32'hFF000300, 3, 510};
      vecs[3] = '{4'b0100, 32'h00800000, 32'h00800000, 2, 256};
      vecs[4] = '{4'b0011, 32'h00000001, 32'h000000FE, 0, 255};
      vecs[5] = '{4'b1111, 32'h00000900, 32'h0000FA00, 1, 259};
      vecs[6] = '{4'b1001, 32'h00000000, 32'h00000000, 3, 0};

      doReset();
      checkOutput("reset add_vld", 32'(add_vld), 0);
      checkOutput("reset add_a", 32'(add_a), 0);
      checkOutput("reset add_b", 32'(add_b), 0);
      checkOutput("reset rsp_vld", 32'(rsp_vld), 0);
      checkOutput("reset rsp_id", 32'(rsp_id), 0);
      checkOutput("reset rsp_data", 32'(rsp_data), 0);
      checkOutput("reset rsp_err", 32'(rsp_err), 0);
      checkOutput("reset busy", 32'(busy), 0);
      checkOutput("reset req_rdy", 32'(req_rdy), 0);

      // Single request latency: accept T, issue T+1, result T+3.
      applyStimulus(4'b0001, 32'd200, 32'd100);
      checkOutput("t1 req_rdy at T", 32'(req_rdy), 32'b0001);
      tick();
      req_vld = '0;
      checkOutput("t1 add_vld at T+1", 32'(add_vld), 1);
      checkOutput("t1 add_a", 32'(add_a), 200);
      checkOutput("t1 add_b", 32'(add_b), 100);
      checkOutput("t1 busy", 32'(busy), 1);
      tick();
      checkOutput("t1 add_vld at T+2", 32'(add_vld), 0);
      checkOutput("t1 rsp_vld at T+2", 32'(rsp_vld), 0);
      tick();
      checkOutput("t1 rsp_vld at T+3", 32'(rsp_vld), 1);
      checkOutput("t1 rsp_data", 32'(rsp_data), 300);
      checkOutput("t1 rsp_id", 32'(rsp_id), 0);
      checkOutput("t1 rsp_err", 32'(rsp_err), 0);
      tick();
      checkOutput("t1 rsp_vld after handshake", 32'(rsp_vld), 0);
      checkOutput("t1 busy after handshake", 32'(busy), 0);

      // Table of single operations with hand-computed winners and sums.
      for (int v = 0; v < 7; v++) begin
         applyStimulus(vecs[v].vld, vecs[v].a, vecs[v].b);
         checkOutput($sformatf("vec%0d req_rdy", v), 32'(req_rdy), 32'(1) << vecs[v].expId);
         tick();
         req_vld = '0;
         waitRsp(10);
         checkOutput($sformatf("vec%0d rsp_id", v), 32'(rsp_id), 32'(vecs[v].expId));
         checkOutput($sformatf("vec%0d rsp_data", v), 32'(rsp_data), 32'(vecs[v].expSum));
         checkOutput($sformatf("vec%0d rsp_err", v), 32'(rsp_err), 0);
         tick();
      end

      // All requesters held: IDs rotate 0,1,2,3,0,1.
      doReset();
      applyStimulus(4'b1111, 32'h0D0C0B0A, 32'h3C281400);
      nRsp = 0;
      for (int c = 0; c < 60 && nRsp < 6; c++) begin
         checkOutput("rr req_rdy at most one", 32'($countones(req_rdy) <= 1), 1);
         if (rsp_vld) begin
            checkOutput("rr rsp_id", 32'(rsp_id), 32'(expIds[nRsp]));
            checkOutput("rr rsp_data", 32'(rsp_data), 32'(laneSum(req_a, req_b, expIds[nRsp])));
            nRsp++;
            if (nRsp == 6) req_vld = '0;
         end
         if (nRsp < 6) tick();
      end
      checkOutput("rr response count", 32'(nRsp), 6);
      tick();
      tick();

      // Backpressure while other requesters are pending.
      applyStimulus(4'b0100, 32'h00320000, 32'h003C0000);
      rsp_rdy = 1'b0;
      checkOutput("bp grant", 32'(req_rdy), 32'b0100);
      tick();
      req_vld = 4'b1111;
      waitRsp(10);
      for (int c = 0; c < 5; c++) begin
         checkOutput("bp rsp_vld", 32'(rsp_vld), 1);
         checkOutput("bp rsp_id", 32'(rsp_id), 2);
         checkOutput("bp rsp_data", 32'(rsp_data), 110);
         checkOutput("bp req_rdy", 32'(req_rdy), 0);
         checkOutput("bp add_vld", 32'(add_vld), 0);
         tick();
      end
      rsp_rdy = 1'b1;
      req_vld = '0;
      #1;
      checkOutput("bp rsp_vld on handshake", 32'(rsp_vld), 1);
      tick();
      checkOutput("bp rsp_vld after handshake", 32'(rsp_vld), 0);
      checkOutput("bp busy after handshake", 32'(busy), 0);
      req_vld = 4'b1000;
      #1;
      checkOutput("bp idle grant", 32'(req_rdy), 32'b1000);
      req_vld = '0;
      #1;

      // Timeout: adder never answers; 15 wait cycles then error.
      silent = 1'b1;
      applyStimulus(4'b0001, 32'h00000005, 32'h00000006);
      checkOutput("to grant", 32'(req_rdy), 32'b0001);
      tick();
      req_vld = '0;
      n = 0;
      while (!rsp_vld && n < 40) begin
         tick();
         n++;
      end
      checkOutput("to cycles to response", 32'(n), 16);
      checkOutput("to rsp_err", 32'(rsp_err), 1);
      checkOutput("to rsp_data", 32'(rsp_data), 0);
      checkOutput("to rsp_id", 32'(rsp_id), 0);
      tick();
      silent = 1'b0;
      applyStimulus(4'b0010, 32'h00000700, 32'h00000900);
      checkOutput("to next grant", 32'(req_rdy), 32'b0010);
      tick();
      req_vld = '0;
      waitRsp(10);
      checkOutput("to next rsp_id", 32'(rsp_id), 1);
      checkOutput("to next rsp_data", 32'(rsp_data), 16);
      checkOutput("to next rsp_err", 32'(rsp_err), 0);
      tick();

      // Reset during WAIT with requester 1 pending.
      silent = 1'b1;
      applyStimulus(4'b0010, 32'h0000FF00, 32'h0000FF00);
      tick();
      tick();
      tick();
      rst_in = 1'b1;
      #1;
      checkOutput("mid-reset add_vld", 32'(add_vld), 0);
      checkOutput("mid-reset add_a", 32'(add_a), 0);
      checkOutput("mid-reset add_b", 32'(add_b), 0);
      checkOutput("mid-reset rsp_vld", 32'(rsp_vld), 0);
      checkOutput("mid-reset rsp_id", 32'(rsp_id), 0);
      checkOutput("mid-reset rsp_data", 32'(rsp_data), 0);
      checkOutput("mid-reset rsp_err", 32'(rsp_err), 0);
      checkOutput("mid-reset busy", 32'(busy), 0);
      silent = 1'b0;
      tick();
      rst_in = 1'b0;
      #1;
      checkOutput("post-reset grant", 32'(req_rdy), 32'b0010);
      tick();
      req_vld = '0;
      waitRsp(10);
      checkOutput("post-reset rsp_id", 32'(rsp_id), 1);
      checkOutput("post-reset rsp_data", 32'(rsp_data), 510);
      checkOutput("post-reset rsp_err", 32'(rsp_err), 0);
      tick();

      // Stray adder result while idle.
      manualData = 9'd123;
      manualVld  = 1'b1;
      tick();
      manualVld = 1'b0;
      checkOutput("stray rsp_vld", 32'(rsp_vld), 0);
      checkOutput("stray busy", 32'(busy), 0);
      tick();
      checkOutput("stray rsp_vld later", 32'(rsp_vld), 0);

      // Result arriving on the final wait cycle wins over the timeout.
      silent = 1'b1;
      applyStimulus(4'b0001, 32'h00000003, 32'h00000004);
      tick();
      req_vld = '0;
      repeat (15) tick();
      checkOutput("edge still waiting", 32'(rsp_vld), 0);
      manualData = 9'd77;
      manualVld  = 1'b1;
      tick();
      manualVld = 1'b0;
      checkOutput("edge rsp_vld", 32'(rsp_vld), 1);
      checkOutput("edge rsp_err", 32'(rsp_err), 0);
      checkOutput("edge rsp_data", 32'(rsp_data), 77);
      checkOutput("edge rsp_id", 32'(rsp_id), 0);
      tick();
      silent = 1'b0;

      // Randomized traffic against a round-robin/queue reference model.
      doReset();
      mLast   = 3;
      nRspRnd = 0;
      for (int c = 0; c < 400; c++) begin
         req_vld = 4'($urandom_range(0, 15));
         req_a   = $urandom;
         req_b   = $urandom;
         rsp_rdy = ($urandom_range(0, 3) != 0);
         #1;
         checkOutput("rnd req_rdy at most one", 32'($countones(req_rdy) <= 1), 1);
         if (req_rdy != 0) begin
            w = modelWinner(mLast, req_vld);
            checkOutput("rnd grant", 32'(req_rdy), (w < 0) ? 32'(0) : (32'(1) << w));
            if (w >= 0) begin
               mLast = w;
               e.id  = w;
               e.sum = laneSum(req_a, req_b, w);
               expQ.push_back(e);
            end
         end
         scoreRsp();
         tick();
      end
      req_vld = '0;
      rsp_rdy = 1'b1;
      #1;
      for (int c = 0; c < 20; c++) begin
         scoreRsp();
         tick();
      end
      checkOutput("rnd queue drained", 32'(expQ.size()), 0);
      checkOutput("rnd enough responses", 32'(nRspRnd >= 20), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
